// File: rtl/button_debouncer.sv
// Debounces a raw asynchronous button into a clean level: synchronizer chain,
// stability counter and four-state settle FSM with registered level/busy outputs.
module button_debouncer #(
  parameter int   STABLE_CYCLES = 1000,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic in_clock,
  input  logic in_reset,
  input  logic in_button,
  output logic out_level,
  output logic out_busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   busy_q, busy_d;

  // True when the sample being taken this cycle completes the stability window.
  function automatic logic settled(input logic [CNT_W-1:0] cnt);
    return ({1'b0, cnt} + (CNT_W + 1)'(1)) == LIMIT;
  endfunction

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      sync_chain_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], in_button};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      STABLE_LOW: begin
        if (sync_q) begin
          if (STABLE_CYCLES == 1) begin
            level_d = 1'b1;
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (settled(cnt_q)) begin
          level_d = 1'b1;
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync_q) begin
          if (STABLE_CYCLES == 1) begin
            level_d = 1'b0;
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (settled(cnt_q)) begin
          level_d = 1'b0;
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
    // Busy is registered, so it is derived from the state being entered.
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign out_level = level_q;
  assign out_busy  = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: three instances cover the short-window,
// single-cycle/reset-high and default-parameter configurations.
module tb_button_debouncer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, btn_a, lvl_a, busy_a;
  logic rst_b, btn_b, lvl_b, busy_b;
  logic rst_c, btn_c, lvl_c, busy_c;

  button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) dut_a (
    .in_clock(clk), .in_reset(rst_a), .in_button(btn_a), .out_level(lvl_a), .out_busy(busy_a)
  );
  button_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)) dut_b (
    .in_clock(clk), .in_reset(rst_b), .in_button(btn_b), .out_level(lvl_b), .out_busy(busy_b)
  );
  button_debouncer dut_c (
    .in_clock(clk), .in_reset(rst_c), .in_button(btn_c), .out_level(lvl_c), .out_busy(busy_c)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge monitors sampled on the falling edge, away from the active edge.
  int   rises_a = 0, rises_c = 0, toggles_c = 0;
  logic prev_a = 1'b0, prev_c = 1'b0;
  logic mon_b = 1'b0, saw_busy_b = 1'b0;
  always @(negedge clk) begin
    if (lvl_a && !prev_a) rises_a++;
    prev_a = lvl_a;
    if (lvl_c !== prev_c) toggles_c++;
    if (lvl_c && !prev_c) rises_c++;
    prev_c = lvl_c;
    if (mon_b && busy_b) saw_busy_b = 1'b1;
  end

  logic       saw_busy, saw_level;
  logic [5:0] bounce;
  int         r0;

  initial begin
    rst_a = 1'b1; btn_a = 1'b0;
    rst_b = 1'b1; btn_b = 1'b0;
    rst_c = 1'b1; btn_c = 1'b0;
    tick(2);
    expect_eq("reset_level_a", lvl_a, 0);
    expect_eq("reset_busy_a", busy_a, 0);
    rst_a = 1'b0;
    tick(1);

    // Clean press and release.
    btn_a = 1'b1;
    tick(2);
    expect_eq("press_busy_e2", busy_a, 0);
    tick(1);
    expect_eq("press_busy_e3", busy_a, 1);
    expect_eq("press_level_e3", lvl_a, 0);
    tick(2);
    expect_eq("press_level_e5", lvl_a, 0);
    expect_eq("press_busy_e5", busy_a, 1);
    tick(1);
    expect_eq("press_level_e6", lvl_a, 1);
    expect_eq("press_busy_e6", busy_a, 0);
    btn_a = 1'b0;
    tick(5);
    expect_eq("release_level_e5", lvl_a, 1);
    tick(1);
    expect_eq("release_level_e6", lvl_a, 0);
    tick(4);

    // Three-cycle glitch must never reach the level.
    saw_busy = 1'b0; saw_level = 1'b0;
    btn_a = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) btn_a = 1'b0;
      tick(1);
      if (busy_a) saw_busy = 1'b1;
      if (lvl_a) saw_level = 1'b1;
    end
    expect_eq("glitch_busy_pulsed", saw_busy, 1);
    expect_eq("glitch_level_quiet", saw_level, 0);
    expect_eq("glitch_end_busy", busy_a, 0);
    expect_eq("glitch_end_level", lvl_a, 0);

    // Bounce train 1,0,1,1,0,1 then held high.
    r0 = rises_a;
    bounce = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      btn_a = bounce[5-i];
      tick(1);
    end
    expect_eq("bounce_level_run_e1", lvl_a, 0);
    tick(4);
    expect_eq("bounce_level_run_e5", lvl_a, 0);
    tick(1);
    expect_eq("bounce_level_run_e6", lvl_a, 1);
    tick(6);
    expect_eq("bounce_single_rise", rises_a - r0, 1);

    btn_a = 1'b0;
    tick(10);
    expect_eq("bounce_released", lvl_a, 0);

    // Reset while in WAIT_HIGH with a partial count.
    btn_a = 1'b1;
    tick(5);
    expect_eq("midwait_busy", busy_a, 1);
    expect_eq("midwait_cnt", 32'(dut_a.cnt_q), 3);
    rst_a = 1'b1;
    tick(1);
    expect_eq("midwait_rst_level", lvl_a, 0);
    expect_eq("midwait_rst_busy", busy_a, 0);
    rst_a = 1'b0;
    tick(5);
    expect_eq("postrst_level_e5", lvl_a, 0);
    tick(1);
    expect_eq("postrst_level_e6", lvl_a, 1);

    // RESET_LEVEL=1 with a one-cycle window.
    mon_b = 1'b1;
    tick(1);
    expect_eq("rl1_level_in_reset", lvl_b, 1);
    expect_eq("rl1_busy_in_reset", busy_b, 0);
    rst_b = 1'b0;
    tick(2);
    expect_eq("rl1_level_e2", lvl_b, 1);
    tick(1);
    expect_eq("rl1_level_e3", lvl_b, 0);
    tick(4);
    expect_eq("rl1_busy_never", saw_busy_b, 0);
    expect_eq("rl1_level_hold", lvl_b, 0);

    // Long hold with default parameters.
    rst_c = 1'b0;
    tick(1);
    r0 = rises_c;
    btn_c = 1'b1;
    tick(1001);
    expect_eq("long_level_e1001", lvl_c, 0);
    expect_eq("long_busy_e1001", busy_c, 1);
    tick(1);
    expect_eq("long_level_e1002", lvl_c, 1);
    expect_eq("long_busy_e1002", busy_c, 0);
    tick(3998);
    expect_eq("long_single_rise", rises_c - r0, 1);
    expect_eq("long_toggles", toggles_c, 1);
    expect_eq("long_cnt_idle", 32'(dut_c.cnt_q), 0);
    expect_eq("long_level_end", lvl_c, 1);
    expect_eq("long_busy_end", busy_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw, asynchronous, bouncing push-button or switch input into a clean, single-clock-domain level. It sits directly upstream of the edge detector: its `out_level` drives the detector's `in_signal`, so each physical press yields exactly one strobe. It contains a multi-flop synchronizer, a stability counter and a four-state settle FSM.

## Interface
- `STABLE_CYCLES`, default 1000: consecutive synchronized samples that must differ from `out_level` before `out_level` follows them. Legal range is 1 or more.
- `SYNC_STAGES`, default 2: synchronizer depth. Legal range is 2 or more.
- `RESET_LEVEL`, default 0: value loaded into the synchronizer flops and `out_level` on reset.
- `in_clock`  in  1: the only clock. All state updates on its rising edge.
- `in_reset`  in  1: synchronous, active-high reset. Dominates every other input.
- `in_button`  in  1: raw asynchronous input. Can glitch or bounce at any time.
- `out_level`  out  1: debounced level, registered.
- `out_busy`  out  1: high while a level change is pending, i.e. the FSM is in a WAIT state. Registered.

## Operation
- **Synchronizer.** A chain of `SYNC_STAGES` flops samples `in_button`. The last stage is `sync_q`. Only `sync_q` feeds the logic.
- **Counter.** Width is `$clog2(STABLE_CYCLES+1)`. It never exceeds `STABLE_CYCLES`, so it cannot wrap.
- **FSM states:** STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- **STABLE_LOW** (`out_level`=0):
  - `sync_q`=1 with `STABLE_CYCLES`=1: set `out_level`<=1 and go to STABLE_HIGH.
  - `sync_q`=1 otherwise: go to WAIT_HIGH with cnt<=1.
  - else: stay, cnt<=0.
- **WAIT_HIGH:**
  - `sync_q`=0 (bounce): go to STABLE_LOW, cnt<=0, `out_level` unchanged.
  - `sync_q`=1 and cnt+1==`STABLE_CYCLES`: set `out_level`<=1, go to STABLE_HIGH, cnt<=0.
  - otherwise: cnt<=cnt+1.
- **STABLE_HIGH and WAIT_LOW** mirror the two states above with the levels inverted.
- **`out_busy`** is 1 exactly in WAIT_HIGH and WAIT_LOW.
- **Reset** sets:
  - all synchronizer flops and `out_level` to `RESET_LEVEL`;
  - cnt to 0 and `out_busy` to 0;
  - the state to STABLE_LOW if `RESET_LEVEL`=0, else STABLE_HIGH.
- **Reset mid-WAIT** discards the partial count. No `out_level` change results from the pending transition.
- `out_level` never changes except through a completed WAIT sequence, so it produces no glitches.

## Timing
- Sample `in_button` changes to its new value and holds it. Let edge 1 be the first rising edge that samples the new value.
  - `sync_q` shows the new value after edge `SYNC_STAGES`.
  - `out_busy` rises after edge `SYNC_STAGES`+1 (this applies only when `STABLE_CYCLES` ≥ 2).
  - `out_level` changes after edge `SYNC_STAGES`+`STABLE_CYCLES`.
  - `out_busy` falls on that same edge.
- With the defaults the latency is 1002 cycles.
- Any reversion of `sync_q` inside the window restarts the count from zero the next time `sync_q` differs.
- A pulse on `in_button` shorter than `STABLE_CYCLES` cycles, once synchronized, never reaches `out_level`.
- Minimum spacing between two `out_level` transitions is `STABLE_CYCLES` cycles.
- `in_reset` asserted on an edge takes effect on that edge:
  - outputs show reset values from that edge onward;
  - the first post-reset sample enters the synchronizer on the first edge with `in_reset`=0.

## Test plan
- **Clean press** (`STABLE_CYCLES`=4, `SYNC_STAGES`=2, reset 0): raise `in_button` and hold.
  - `out_busy`=1 after edge 3.
  - `out_level`=1 and `out_busy`=0 after edge 6.
  - Release and hold: `out_level`=0 exactly 6 edges later.
- **Short glitch** (`STABLE_CYCLES`=4): in_button high for 3 cycles, then low.
  - `out_busy` pulses high.
  - `out_level` stays 0 throughout.
  - FSM returns to STABLE_LOW.
- **Bounce train** (`STABLE_CYCLES`=4): pattern 1,0,1,1,0,1 followed by 1 held.
  - `out_level` rises exactly 6 edges after the first sample of the final uninterrupted run of 1s.
  - Exactly one rising transition occurs overall.
- **Reset mid-WAIT**: reach WAIT_HIGH with cnt=3, then pulse `in_reset` for 1 cycle while in_button stays high.
  - After the reset edge: `out_level`=0, `out_busy`=0.
  - `out_level` then rises 6 edges after the first post-reset edge.
- **RESET_LEVEL=1** (`STABLE_CYCLES`=1): hold reset with in_button=0.
  - `out_level`=1 during reset.
  - After release, `out_level`=0 on the 3rd edge.
  - `out_busy` never asserts.
- **Long hold**: in_button high for 5000 cycles with defaults.
  - Exactly one `out_level` rise, at edge 1002.
  - No further toggles; cnt stays 0 in STABLE_HIGH.
